// File: rtl/arythcrypt_pkg.sv
// ============================================================================
// Module  : arythcrypt_pkg
// Purpose : Shared types and defaults for the arithmetic crypto-core
//           operation scheduler: FSM state encoding, idle opcode and the
//           default operand/opcode widths.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arythcrypt_pkg;

    localparam int DW_DEF       = 8;
    localparam int OPW_DEF      = 4;
    localparam int CORE_LAT_DEF = 2;

    // Control value presented to the core whenever no command is executing.
    localparam logic [OPW_DEF-1:0] OP_IDLE = 4'h0;

    // Latency counter only needs to reach CORE_LAT-1, and CORE_LAT tops out at 15.
    localparam int CNTW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : arythcrypt_pkg

`default_nettype wire

// File: rtl/arythcrypt_rr_arb2.sv
// ============================================================================
// Module  : arythcrypt_rr_arb2
// Purpose : Two-way round-robin grant. A lone requester is always granted;
//           when both request, the side named by rr_ptr wins.
// Ports   : valid[1:0] in  - request lines
//           rr_ptr     in  - preferred side under contention
//           gnt[1:0]   out - one-hot grant (all zero when nobody requests)
//           id         out - index of the granted side
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arythcrypt_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] gnt,
    output logic       id
);

    always_comb begin
        gnt = 2'b00;
        id  = 1'b0;
        if (valid == 2'b11) begin
            id  = rr_ptr;
            gnt = rr_ptr ? 2'b10 : 2'b01;
        end else if (valid[0]) begin
            id  = 1'b0;
            gnt = 2'b01;
        end else if (valid[1]) begin
            id  = 1'b1;
            gnt = 2'b10;
        end
    end

endmodule : arythcrypt_rr_arb2

`default_nettype wire

// File: rtl/arythcrypt_op_sched.sv
// ============================================================================
// Module  : arythcrypt_op_sched
// Purpose : Round-robin scheduler sharing one arithmetic crypto core between
//           two requesters. One {op, A, B} command is in flight at a time; it
//           is held on the core for CORE_LAT cycles, the core OUTPUT is then
//           captured and returned with the requester id on a valid/ready port.
// Ports   : CLK, Reset (async, active high)
//           reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b - command ports N=0,1
//           core_i1/core_i2/core_ctrl out, core_result in - core interface
//           rsp_valid/rsp_ready/rsp_data/rsp_id - response port
//           busy     - high whenever the FSM is not idle
//           done_cnt - completed responses, wraps 255 -> 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arythcrypt_op_sched #(
    parameter int             DW       = 8,
    parameter int             OPW      = 4,
    parameter int             CORE_LAT = 2,
    parameter logic [OPW-1:0] OP_IDLE  = OPW'(arythcrypt_pkg::OP_IDLE)
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic [DW-1:0]  core_i1,
    output logic [DW-1:0]  core_i2,
    output logic [OPW-1:0] core_ctrl,
    input  logic [DW-1:0]  core_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_id,
    output logic           busy,
    output logic [7:0]     done_cnt
);

    import arythcrypt_pkg::*;

    state_t              state_q, state_d;
    logic                rr_ptr_q;
    logic [OPW-1:0]      op_q;
    logic [DW-1:0]       a_q, b_q;
    logic [DW-1:0]       rsp_data_q;
    logic                rsp_id_q;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [7:0]          done_cnt_q;

    logic [1:0]          gnt;
    logic                gnt_id;
    logic                accept;
    logic                rsp_fire;

    arythcrypt_rr_arb2 u_arb (
        .valid  ({req1_valid, req0_valid}),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .id     (gnt_id)
    );

    // Grants are only honoured while idle; any other state blocks both sides.
    assign req0_ready = (state_q == IDLE) && gnt[0];
    assign req1_ready = (state_q == IDLE) && gnt[1];
    assign accept     = req0_ready || req1_ready;
    assign rsp_fire   = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = CNTW'(CORE_LAT - 1);
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Returning to IDLE rather than accepting here leaves one bubble.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q     <= gnt_id ? req1_op : req0_op;
                a_q      <= gnt_id ? req1_a  : req0_a;
                b_q      <= gnt_id ? req1_b  : req0_b;
                rsp_id_q <= gnt_id;
                rr_ptr_q <= ~gnt_id;
            end
            if ((state_q == EXEC) && (cnt_q == '0)) begin
                rsp_data_q <= core_result;
            end
            if (rsp_fire) begin
                done_cnt_q <= done_cnt_q + 8'd1;
            end
        end
    end

    // Operands stay on the core after EXEC; only Control drops back to idle.
    assign core_i1   = a_q;
    assign core_i2   = b_q;
    assign core_ctrl = (state_q == EXEC) ? op_q : OP_IDLE;

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;

endmodule : arythcrypt_op_sched

`default_nettype wire
